// File: rtl/seq_scan_controller_if.sv
// Handshake bundle between a parallel word producer, the scan controller and its result consumer.
// Latency: none, wires only.
// Backpressure: o_ready gates word intake; i_res_ready gates result retirement.
//
// Ports (signal names follow the controller's point of view):
//   i_data/i_valid/o_ready    word intake handshake
//   i_flush                   clear detection history (IDLE only)
//   o_bit/o_bit_valid/o_match serial bit stream and per-bit match flag
//   o_count/o_res_valid/i_res_ready  per-word result handshake
interface seq_scan_controller_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              i_flush;
  logic              o_bit;
  logic              o_bit_valid;
  logic              o_match;
  logic [CNT_W-1:0]  o_count;
  logic              o_res_valid;
  logic              i_res_ready;

  // Producer/consumer side.
  modport master (
    output i_data, i_valid, i_flush, i_res_ready,
    input  o_ready, o_bit, o_bit_valid, o_match, o_count, o_res_valid
  );

  // Controller side.
  modport slave (
    input  i_data, i_valid, i_flush, i_res_ready,
    output o_ready, o_bit, o_bit_valid, o_match, o_count, o_res_valid
  );
endinterface

// File: rtl/seq_scan_controller.sv
// Serializes accepted words MSB-first and counts overlapping pattern matches per word.
// Latency: bit k of a word appears k cycles after its accept edge; result after DATA_W cycles.
// Backpressure: o_ready only in IDLE; result held stable in REPORT until i_res_ready.
//
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-high reset
//   bus      seq_scan_controller_if.slave (word intake, serial bit stream, result handshake)
module seq_scan_controller #(
  parameter int                 DATA_W  = 16,
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PAT     = 5'b10110,
  parameter int                 CNT_W   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  seq_scan_controller_if.slave  bus
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]  shreg;
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [BW-1:0]      bitcnt;
  logic               bit_r;
  logic               bit_vld_r;
  logic               match_r;
  logic [CNT_W-1:0]   count;
  logic               ready_c;
  logic               res_vld_c;

  logic               cur_bit;
  logic [PAT_LEN-1:0] window;
  logic               fill_ok;
  logic               hit;
  logic               last_bit;

  assign cur_bit  = shreg[DATA_W-1];
  assign window   = {hist, cur_bit};
  // The current bit completes a full window only once PAT_LEN-1 real bits
  // sit in history; otherwise zeroed history could fake a match.
  assign fill_ok  = (fill >= (FILL_MAX - 1'b1));
  assign hit      = fill_ok && (window == PAT);
  assign last_bit = (bitcnt == LAST_BIT);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.i_valid)     state_nxt = S_SHIFT;
      S_SHIFT:  if (last_bit)        state_nxt = S_REPORT;
      S_REPORT: if (bus.i_res_ready) state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_c   = 1'b0;
    res_vld_c = 1'b0;
    case (state)
      S_IDLE:   ready_c   = 1'b1;
      S_REPORT: res_vld_c = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: shifter, history, counters and registered bit outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shreg     <= '0;
      hist      <= '0;
      fill      <= '0;
      bitcnt    <= '0;
      bit_r     <= 1'b0;
      bit_vld_r <= 1'b0;
      match_r   <= 1'b0;
      count     <= '0;
    end else begin
      bit_vld_r <= 1'b0;
      match_r   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Flush and accept may coincide: the new word then starts with empty history.
          if (bus.i_flush) begin
            hist <= '0;
            fill <= '0;
          end
          if (bus.i_valid) begin
            shreg  <= bus.i_data;
            count  <= '0;
            bitcnt <= '0;
          end
        end
        S_SHIFT: begin
          shreg     <= {shreg[DATA_W-2:0], 1'b0};
          bit_r     <= cur_bit;
          bit_vld_r <= 1'b1;
          hist      <= window[PAT_LEN-2:0];
          if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
          end
          match_r   <= hit;
          if (hit && (count != '1)) begin
            count <= count + 1'b1;
          end
          bitcnt    <= bitcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready     = ready_c;
  assign bus.o_res_valid = res_vld_c;
  assign bus.o_bit       = bit_r;
  assign bus.o_bit_valid = bit_vld_r;
  assign bus.o_match     = match_r;
  assign bus.o_count     = count;

endmodule

// File: tb/tb_seq_scan_controller.sv
// Bench for seq_scan_controller: three instances (default pattern, all-zero
// pattern, 1-bit count) run in lockstep on identical stimulus and are checked
// against a bit-history reference model.
module tb_seq_scan_controller;

  localparam int DW = 16;
  localparam int PL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_scan_controller_if #(.DATA_W(DW), .CNT_W(5)) ifa ();
  seq_scan_controller_if #(.DATA_W(DW), .CNT_W(5)) ifb ();
  seq_scan_controller_if #(.DATA_W(DW), .CNT_W(1)) ifc ();

  assign ifb.i_data      = ifa.i_data;
  assign ifb.i_valid     = ifa.i_valid;
  assign ifb.i_flush     = ifa.i_flush;
  assign ifb.i_res_ready = ifa.i_res_ready;
  assign ifc.i_data      = ifa.i_data;
  assign ifc.i_valid     = ifa.i_valid;
  assign ifc.i_flush     = ifa.i_flush;
  assign ifc.i_res_ready = ifa.i_res_ready;

  seq_scan_controller #(.DATA_W(DW), .PAT_LEN(PL), .PAT(5'b10110), .CNT_W(5)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa)
  );
  seq_scan_controller #(.DATA_W(DW), .PAT_LEN(PL), .PAT(5'b00000), .CNT_W(5)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb)
  );
  seq_scan_controller #(.DATA_W(DW), .PAT_LEN(PL), .PAT(5'b10110), .CNT_W(1)) dut_c (
    .i_clk(clk), .i_reset(rst), .bus(ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the bits seen since the last reset/flush (at most PL kept),
  // and per-instance pattern, saturation limit, match flag and word count.
  logic           hist_q[$];
  logic [PL-1:0]  pats[3];
  int             cmax[3];
  int             cnt[3];
  logic           m[3];

  function automatic logic pat_hit(input logic [PL-1:0] p);
    if (hist_q.size() != PL) return 1'b0;
    for (int j = 0; j < PL; j++) begin
      if (hist_q[j] !== p[PL-1-j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_bit(input logic b);
    hist_q.push_back(b);
    if (hist_q.size() > PL) void'(hist_q.pop_front());
    for (int c = 0; c < 3; c++) begin
      m[c] = pat_hit(pats[c]);
      if (m[c] && cnt[c] < cmax[c]) cnt[c]++;
    end
  endtask

  task automatic model_clr_match();
    for (int c = 0; c < 3; c++) m[c] = 1'b0;
  endtask

  task automatic model_reset();
    hist_q.delete();
    model_clr_match();
    for (int c = 0; c < 3; c++) cnt[c] = 0;
  endtask

  task automatic chk_dut(input string nm, input logic b, input logic v, input logic mt,
                         input logic [31:0] c, input logic r, input logic rv,
                         input logic eb, input logic ev, input logic em,
                         input int ec, input logic er, input logic erv);
    check({nm, ".bit_valid"}, 32'(v), 32'(ev));
    check({nm, ".match"}, 32'(mt), 32'(em));
    check({nm, ".count"}, c, 32'(ec));
    check({nm, ".ready"}, 32'(r), 32'(er));
    check({nm, ".res_valid"}, 32'(rv), 32'(erv));
    if (ev) check({nm, ".bit"}, 32'(b), 32'(eb));
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic ev,
                         input logic er, input logic erv);
    chk_dut({tag, ".a"}, ifa.o_bit, ifa.o_bit_valid, ifa.o_match, 32'(ifa.o_count),
            ifa.o_ready, ifa.o_res_valid, eb, ev, m[0], cnt[0], er, erv);
    chk_dut({tag, ".b"}, ifb.o_bit, ifb.o_bit_valid, ifb.o_match, 32'(ifb.o_count),
            ifb.o_ready, ifb.o_res_valid, eb, ev, m[1], cnt[1], er, erv);
    chk_dut({tag, ".c"}, ifc.o_bit, ifc.o_bit_valid, ifc.o_match, 32'(ifc.o_count),
            ifc.o_ready, ifc.o_res_valid, eb, ev, m[2], cnt[2], er, erv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset.bit", 32'(ifa.o_bit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // flush_mode: 0 none, 1 flush pulse in a separate IDLE cycle, 2 flush with the accept.
  // hold: cycles of i_res_ready=0 (with i_valid=1) in REPORT.
  // abort_k: nonzero -> assert reset right after bit abort_k.
  task automatic run_word(input logic [DW-1:0] data, input int flush_mode,
                          input int hold, input int abort_k);
    string tg;
    if (flush_mode == 1) begin
      @(negedge clk);
      ifa.i_flush = 1'b1;
      @(posedge clk);
      #1;
      ifa.i_flush = 1'b0;
      hist_q.delete();
      model_clr_match();
      chk_all("flush", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    ifa.i_data  = data;
    ifa.i_valid = 1'b1;
    ifa.i_flush = (flush_mode == 2);
    @(posedge clk);
    #1;
    ifa.i_valid = 1'b0;
    ifa.i_flush = 1'b0;
    if (flush_mode == 2) hist_q.delete();
    model_clr_match();
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    chk_all($sformatf("w%04h.accept", data), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= DW; k++) begin
      @(posedge clk);
      #1;
      model_bit(data[DW-k]);
      tg = $sformatf("w%04h.k%0d", data, k);
      chk_all(tg, data[DW-k], 1'b1, 1'b0, (k == DW));
      if (k == abort_k) begin
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all({tg, ".async_rst"}, 1'b0, 1'b0, 1'b1, 1'b0);
        check({tg, ".rst_bit"}, 32'(ifa.o_bit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    model_clr_match();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ifa.i_valid = 1'b1;
      @(posedge clk);
      #1;
      chk_all($sformatf("w%04h.hold%0d", data, h), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    ifa.i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.i_res_ready = 1'b0;
    ifa.i_valid     = 1'b0;
    chk_all($sformatf("w%04h.idle", data), 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int fm, hold, ab;
    pats[0] = 5'b10110; cmax[0] = 31;
    pats[1] = 5'b00000; cmax[1] = 31;
    pats[2] = 5'b10110; cmax[2] = 1;
    model_reset();
    ifa.i_data      = '0;
    ifa.i_valid     = 1'b0;
    ifa.i_flush     = 1'b0;
    ifa.i_res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("por", 1'b0, 1'b0, 1'b1, 1'b0);
    check("por.bit", 32'(ifa.o_bit), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill guard: all-zero pattern against an all-zero word right after reset.
    run_word(16'h0000, 0, 0, 0);
    check("fill_guard.b_count", 32'(ifb.o_count), 32'd12);

    // Single word with defaults, plus 1-bit count saturation.
    do_reset();
    run_word(16'hB6C0, 0, 0, 0);
    check("b6c0.a_count", 32'(ifa.o_count), 32'd3);
    check("b6c0.c_count_sat", 32'(ifc.o_count), 32'd1);

    // Cross-word overlap with and without flush.
    run_word(16'h000B, 1, 0, 0);
    check("xword1.a_count", 32'(ifa.o_count), 32'd0);
    run_word(16'h0000, 0, 0, 0);
    check("xword2.a_count", 32'(ifa.o_count), 32'd1);
    run_word(16'h000B, 0, 0, 0);
    run_word(16'h0000, 1, 0, 0);
    check("xword_flush.a_count", 32'(ifa.o_count), 32'd0);
    run_word(16'h000B, 0, 0, 0);
    run_word(16'h0000, 2, 0, 0);
    check("xword_flush_valid.a_count", 32'(ifa.o_count), 32'd0);

    // Backpressure, then back-to-back accept.
    run_word(16'hB6C0, 0, 4, 0);
    run_word(16'hB6C0, 0, 0, 0);

    // Reset in the middle of SHIFT, then a word that only matches on fresh history.
    run_word(16'hB6C0, 0, 0, 7);
    run_word(16'h6C00, 0, 0, 0);
    check("after_rst.a_count", 32'(ifa.o_count), 32'd1);

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & 16'($urandom) & 16'($urandom);
      fm = $urandom_range(0, 5);
      fm = (fm < 4) ? 0 : fm - 3;
      hold = $urandom_range(0, 3);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, DW) : 0;
      run_word(d, fm, hold, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
